// File: rtl/mdr_bcd_display.sv
// mdr_bcd_display: signed MDR result to BCD via sequential double-dabble, driving 7-segment digits
package mdr_bcd_pkg;
    typedef enum logic [6:0] {
        ZERO  = 7'b1000000, ONE  = 7'b1111001, TWO   = 7'b0100100, TREE  = 7'b0110000,
        FOUR  = 7'b0011001, FIVE = 7'b0010010, SIX   = 7'b0000010, SEVEN = 7'b1111000,
        EIGHT = 7'b0000000, NINE = 7'b0010000, OFF   = 7'b1111111, SIGN  = 7'b0111111
    } sgmnt_e;
endpackage

module mdr_bcd_display
    import mdr_bcd_pkg::*;
#(
    parameter int W_DATA = 16,
    parameter int N_DIG  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 clear_i,
    input  logic [W_DATA-1:0]    data_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic                 neg_o,
    output logic [4*N_DIG-1:0]   bcd_o,
    output logic [7*N_DIG-1:0]   seg_o,
    output logic [6:0]           seg_sign_o
);
    typedef enum logic [1:0] {IDLE, PROCESING, READY, CLEAR} state_e;
    localparam int CW = $clog2(W_DATA + 1);
    localparam logic [CW-1:0] LAST = CW'(W_DATA - 1);
    localparam logic [7*N_DIG-1:0] SEG_RST = {{(N_DIG-1){OFF}}, ZERO};
    state_e               state;
    logic                 sign;
    logic [W_DATA-1:0]    mag;
    logic [4*N_DIG-1:0]   scratch, adj, nxt;
    logic [CW-1:0]        cnt;
    logic [7*N_DIG-1:0]   nxt_seg;
    logic                 blank;
    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = ZERO;
            4'd1: enc = ONE;
            4'd2: enc = TWO;
            4'd3: enc = TREE;
            4'd4: enc = FOUR;
            4'd5: enc = FIVE;
            4'd6: enc = SIX;
            4'd7: enc = SEVEN;
            4'd8: enc = EIGHT;
            4'd9: enc = NINE;
            default: enc = OFF;
        endcase
    endfunction
    // nxt is the scratch after this cycle's add-3/shift; on the last shift it is the final BCD
    always_comb begin
        adj = scratch;
        nxt_seg = SEG_RST;
        blank = 1'b1;
        for (int i = 0; i < N_DIG; i++)
            adj[4*i+:4] = scratch[4*i+:4] >= 4'd5 ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
        nxt = {adj[4*N_DIG-2:0], mag[W_DATA-1]};
        for (int i = N_DIG - 1; i > 0; i--) begin
            blank = blank && nxt[4*i+:4] == 4'd0;
            nxt_seg[7*i+:7] = blank ? OFF : enc(nxt[4*i+:4]);
        end
        nxt_seg[6:0] = enc(nxt[3:0]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sign       <= 1'b0;
            mag        <= '0;
            scratch    <= '0;
            cnt        <= '0;
            busy_o     <= 1'b0;
            ready_o    <= 1'b0;
            neg_o      <= 1'b0;
            bcd_o      <= '0;
            seg_o      <= SEG_RST;
            seg_sign_o <= OFF;
        end else begin
            ready_o <= 1'b0;
            if (state == CLEAR) begin
                neg_o      <= 1'b0;
                bcd_o      <= '0;
                seg_o      <= SEG_RST;
                seg_sign_o <= OFF;
            end
            if (clear_i) begin
                state  <= CLEAR;
                busy_o <= 1'b0;
            end else if (state == IDLE && start_i) begin
                state   <= PROCESING;
                busy_o  <= 1'b1;
                sign    <= data_i[W_DATA-1];
                mag     <= data_i[W_DATA-1] ? ~data_i + 1'b1 : data_i;
                scratch <= '0;
                cnt     <= '0;
            end else if (state == PROCESING) begin
                scratch <= nxt;
                mag     <= {mag[W_DATA-2:0], 1'b0};
                cnt     <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state      <= READY;
                    busy_o     <= 1'b0;
                    ready_o    <= 1'b1;
                    neg_o      <= sign;
                    bcd_o      <= nxt;
                    seg_o      <= nxt_seg;
                    seg_sign_o <= sign ? SIGN : OFF;
                end
            end else if (state != IDLE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mdr_bcd_display.sv
// tb_mdr_bcd_display: vector table, randomized model comparison and clear/reset sequences
module tb_mdr_bcd_display;
    import mdr_bcd_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, clear_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        busy_o, ready_o, neg_o;
    logic [19:0] bcd_o;
    logic [34:0] seg_o;
    logic [6:0]  seg_sign_o;
    int tests = 0, fails = 0;
    localparam logic [34:0] SEG_RST = {OFF, OFF, OFF, OFF, ZERO};
    localparam logic [6:0] LUT [10] = '{ZERO, ONE, TWO, TREE, FOUR, FIVE, SIX, SEVEN, EIGHT, NINE};
    typedef struct {
        logic [15:0] d;
        logic [19:0] bcd;
        logic        neg;
        logic [34:0] seg;
        logic [6:0]  sgn;
    } vec_t;
    vec_t tbl [7];

    mdr_bcd_display #(.W_DATA(16), .N_DIG(5)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i), .data_i(data_i),
        .busy_o(busy_o), .ready_o(ready_o), .neg_o(neg_o), .bcd_o(bcd_o),
        .seg_o(seg_o), .seg_sign_o(seg_sign_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] m_bcd(input int v);
        int a = v < 0 ? -v : v;
        logic [19:0] r;
        for (int i = 0; i < 5; i++) begin
            r[4*i+:4] = 4'(a % 10);
            a = a / 10;
        end
        return r;
    endfunction

    function automatic logic [34:0] m_seg(input int v);
        int a = v < 0 ? -v : v;
        int nd = 1;
        int t = a / 10;
        logic [34:0] r;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        for (int i = 0; i < 5; i++) begin
            r[7*i+:7] = i < nd ? LUT[a % 10] : OFF;
            a = a / 10;
        end
        return r;
    endfunction

    task automatic chk_reset_vals(input string name);
        chk({name, " busy"}, 64'(busy_o), 64'(0));
        chk({name, " ready"}, 64'(ready_o), 64'(0));
        chk({name, " neg"}, 64'(neg_o), 64'(0));
        chk({name, " bcd"}, 64'(bcd_o), 64'(0));
        chk({name, " seg"}, 64'(seg_o), 64'(SEG_RST));
        chk({name, " sign"}, 64'(seg_sign_o), 64'(OFF));
    endtask

    // Returns with the bench sitting in the READY cycle of the conversion
    task automatic convert(input logic [15:0] d, input logic [19:0] e_bcd, input logic e_neg,
                           input logic [34:0] e_seg, input logic [6:0] e_sgn, input int acc_exp,
                           input string name);
        int n = 0;
        int nb = 0;
        start_i = 1'b1;
        data_i = d;
        do begin
            step();
            n++;
        end while (!busy_o && n < 4);
        chk({name, " accept edges"}, 64'(n), 64'(acc_exp));
        start_i = 1'b0;
        n = 0;
        while (!ready_o && n < 40) begin
            if (busy_o) nb++;
            data_i = 16'($urandom);
            step();
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(16));
        chk({name, " busy cycles"}, 64'(nb), 64'(16));
        chk({name, " busy at ready"}, 64'(busy_o), 64'(0));
        chk({name, " bcd"}, 64'(bcd_o), 64'(e_bcd));
        chk({name, " neg"}, 64'(neg_o), 64'(e_neg));
        chk({name, " seg"}, 64'(seg_o), 64'(e_seg));
        chk({name, " sign"}, 64'(seg_sign_o), 64'(e_sgn));
    endtask

    task automatic mconv(input logic [15:0] d, input int acc_exp, input string name);
        int v = int'($signed(d));
        convert(d, m_bcd(v), v < 0, m_seg(v), v < 0 ? SIGN : OFF, acc_exp, name);
    endtask

    initial begin
        int n;
        int v;
        tbl[0] = '{16'd12345, 20'h12345, 1'b0, {ONE, TWO, TREE, FOUR, FIVE}, OFF};
        tbl[1] = '{16'h8000, 20'h32768, 1'b1, {TREE, TWO, SEVEN, SIX, EIGHT}, SIGN};
        tbl[2] = '{16'd0, 20'h00000, 1'b0, {OFF, OFF, OFF, OFF, ZERO}, OFF};
        tbl[3] = '{16'hFFF9, 20'h00007, 1'b1, {OFF, OFF, OFF, OFF, SEVEN}, SIGN};
        tbl[4] = '{16'h7FFF, 20'h32767, 1'b0, {TREE, TWO, SEVEN, SIX, SEVEN}, OFF};
        tbl[5] = '{16'd100, 20'h00100, 1'b0, {OFF, OFF, ONE, ZERO, ZERO}, OFF};
        tbl[6] = '{16'hFC18, 20'h01000, 1'b1, {OFF, ONE, ZERO, ZERO, ZERO}, SIGN};
        repeat (2) step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 7; i++)
            convert(tbl[i].d, tbl[i].bcd, tbl[i].neg, tbl[i].seg, tbl[i].sgn, i == 0 ? 1 : 2,
                    $sformatf("vec%0d", i));
        for (int i = 0; i < 25; i++)
            mconv(16'($urandom), 2, $sformatf("rnd%0d", i));
        // start held high, data wandering: READY ignores start, IDLE accepts on the next edge
        start_i = 1'b1;
        v = int'($signed(16'($urandom)));
        data_i = 16'(v);
        step();
        chk("hold ready ignores start", 64'(busy_o), 64'(0));
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d accept", k), 64'(busy_o), 64'(1));
            n = 0;
            while (!ready_o && n < 40) begin
                data_i = 16'($urandom);
                step();
                n++;
            end
            chk($sformatf("hold%0d latency", k), 64'(n), 64'(16));
            chk($sformatf("hold%0d bcd", k), 64'(bcd_o), 64'(m_bcd(v)));
            chk($sformatf("hold%0d seg", k), 64'(seg_o), 64'(m_seg(v)));
            v = int'($signed(16'($urandom)));
            data_i = 16'(v);
            step();
            chk($sformatf("hold%0d idle gap", k), 64'(busy_o), 64'(0));
            step();
        end
        start_i = 1'b0;
        n = 0;
        while (!ready_o && n < 40) begin
            step();
            n++;
        end
        chk("hold drain bcd", 64'(bcd_o), 64'(m_bcd(v)));
        step();
        // clear 8 cycles into a conversion blanks the previously displayed value
        convert(16'hCFC7, 20'h12345, 1'b1, {ONE, TWO, TREE, FOUR, FIVE}, SIGN, 1, "pre clear");
        step();
        start_i = 1'b1;
        data_i = 16'd999;
        step();
        start_i = 1'b0;
        chk("clr busy", 64'(busy_o), 64'(1));
        repeat (7) step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr busy drop", 64'(busy_o), 64'(0));
        step();
        chk_reset_vals("clr");
        n = 0;
        repeat (20) begin
            if (ready_o) n++;
            step();
        end
        chk("clr no ready", 64'(n), 64'(0));
        convert(16'd999, 20'h00999, 1'b0, {OFF, OFF, NINE, NINE, NINE}, OFF, 1, "post clear");
        step();
        // reset pulse at shift 10
        start_i = 1'b1;
        data_i = 16'hEC3F;
        step();
        start_i = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset_vals("mid rst");
        convert(16'd4321, 20'h04321, 1'b0, {OFF, FOUR, TREE, TWO, ONE}, OFF, 1, "post rst");
        step();
        // clear and start on the same edge: clear wins
        start_i = 1'b1;
        clear_i = 1'b1;
        data_i = 16'd5;
        step();
        start_i = 1'b0;
        clear_i = 1'b0;
        chk("same edge busy", 64'(busy_o), 64'(0));
        step();
        chk_reset_vals("same edge");
        mconv(16'hFFF9, 1, "after same edge");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
